// File: rtl/blob_counter_param.sv
// blob_counter_param: streaming connected-component counter; define BLOB_MAX_AREA_EN to add o_max_area
module blob_counter_param #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int LBL_BITS  = 8,
  parameter int AREA_BITS = 19,
  parameter int CONNECT8  = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [AREA_BITS-1:0] i_min_area,
  input  logic                 i_valid,
  input  logic                 i_pix,
  output logic                 o_ready,
  output logic                 o_valid,
  input  logic                 i_ack,
  output logic [LBL_BITS-1:0]  o_count,
  output logic                 o_overflow
`ifdef BLOB_MAX_AREA_EN
  ,
  output logic [AREA_BITS-1:0] o_max_area
`endif
);
  localparam int NL = 1 << LBL_BITS;
  localparam int CLR_N = NL > IMG_W ? NL : IMG_W;
  localparam int IW = $clog2(CLR_N) + 1;
  localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  typedef logic [LBL_BITS-1:0] lbl_t;
  typedef logic [AREA_BITS-1:0] area_t;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_RESOLVE, S_MERGE, S_COUNT, S_OUT} state_t;
  state_t state, state_nx;
  lbl_t parent [NL];
  area_t area [NL];
  lbl_t lbuf [IMG_W];
  logic [IW-1:0] idx, la_x;
  logic [CW-1:0] col, ne_col;
  logic [RW-1:0] row;
  lbl_t last_alloc, w_q, nw_q;
  area_t thr;
  logic accept, first_col, last_col, last_row, pair, full, root;
  lbl_t n, nw, ne, w, a, b, s, ra, rb, rs, lo, hi, lbl, ix;

  function automatic area_t sat_add(area_t x, area_t y);
    logic [AREA_BITS:0] t;
    t = {1'b0, x} + {1'b0, y};
    return t[AREA_BITS] ? '1 : t[AREA_BITS-1:0];
  endfunction

  assign o_ready = state == S_STREAM;
  assign o_valid = state == S_OUT;

  // Neighbour labels are raw line-buffer values; the parent lookup happens after selection.
  always_comb begin
    accept = state == S_STREAM && i_valid;
    first_col = col == '0;
    last_col = col == CW'(IMG_W - 1);
    last_row = row == RW'(IMG_H - 1);
    ne_col = last_col ? col : col + 1'b1;
    n = row == '0 ? '0 : lbuf[col];
    ne = (row == '0 || last_col) ? '0 : lbuf[ne_col];
    w = first_col ? '0 : w_q;
    nw = first_col ? '0 : nw_q;
    if (CONNECT8 != 0) begin
      pair = n == '0 && ne != '0 && (w != '0 || nw != '0);
      a = w != '0 ? w : nw;
      b = ne;
      s = n != '0 ? n : w != '0 ? w : nw != '0 ? nw : ne;
    end else begin
      pair = w != '0 && n != '0;
      a = w;
      b = n;
      s = w != '0 ? w : n;
    end
    ra = parent[a];
    rb = parent[b];
    rs = parent[s];
    lo = ra < rb ? ra : rb;
    hi = ra < rb ? rb : ra;
    full = last_alloc == '1;
    lbl = !i_pix ? '0 : pair ? lo : s != '0 ? rs : full ? '0 : last_alloc + 1'b1;
    ix = lbl_t'(idx);
    la_x = IW'(last_alloc);
    root = parent[ix] == ix;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (i_start) state_nx = S_CLEAR;
      S_CLEAR:   if (idx == IW'(CLR_N - 1)) state_nx = S_STREAM;
      S_STREAM:  if (accept && last_row && last_col) state_nx = S_RESOLVE;
      S_RESOLVE: if (idx == la_x + 1'b1) state_nx = S_MERGE;
      S_MERGE:   if (idx == '0) state_nx = last_alloc == '0 ? S_OUT : S_COUNT;
      S_COUNT:   if (idx == la_x) state_nx = S_OUT;
      S_OUT:     if (i_ack) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      o_count <= '0;
      o_overflow <= 1'b0;
      idx <= '0;
      row <= '0;
      col <= '0;
      last_alloc <= '0;
      w_q <= '0;
      nw_q <= '0;
      thr <= '0;
`ifdef BLOB_MAX_AREA_EN
      o_max_area <= '0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (i_start) begin
          idx <= '0;
          thr <= i_min_area;
          o_count <= '0;
          o_overflow <= 1'b0;
          last_alloc <= '0;
          row <= '0;
          col <= '0;
`ifdef BLOB_MAX_AREA_EN
          o_max_area <= '0;
`endif
        end
        S_CLEAR: idx <= idx + 1'b1;
        S_STREAM: if (accept) begin
          w_q <= lbl;
          nw_q <= n;
          col <= last_col ? '0 : col + 1'b1;
          row <= last_col ? row + 1'b1 : row;
          idx <= IW'(1);
          if (i_pix && !pair && s == '0) begin
            if (full) o_overflow <= 1'b1;
            else last_alloc <= last_alloc + 1'b1;
          end
        end
        S_RESOLVE: idx <= state_nx == S_MERGE ? la_x : idx + 1'b1;
        S_MERGE: idx <= idx == '0 ? IW'(1) : idx - 1'b1;
        S_COUNT: begin
          idx <= idx + 1'b1;
          if (root && area[ix] >= thr && o_count != '1) o_count <= o_count + 1'b1;
`ifdef BLOB_MAX_AREA_EN
          if (root && area[ix] > o_max_area) o_max_area <= area[ix];
`endif
        end
        default: ;
      endcase
    end
  end

  // Tables need no reset: CLEAR rewrites every entry before a frame uses it.
  always_ff @(posedge i_clk) begin
    case (state)
      S_CLEAR: begin
        if (idx < IW'(NL)) begin
          parent[ix] <= ix;
          area[ix] <= '0;
        end
        if (idx < IW'(IMG_W)) lbuf[CW'(idx)] <= '0;
      end
      S_STREAM: if (accept) begin
        lbuf[col] <= lbl;
        if (i_pix && pair && ra != rb) parent[hi] <= lo;
        if (lbl != '0) area[lbl] <= sat_add(area[lbl], area_t'(1));
      end
      S_RESOLVE: if (idx <= la_x) parent[ix] <= parent[parent[ix]];
      S_MERGE: if (idx != '0 && !root) area[parent[ix]] <= sat_add(area[parent[ix]], area[ix]);
      default: ;
    endcase
  end
endmodule

// File: tb/tb_blob_counter_param.sv
// tb_blob_counter_param: 8x4 frames through 4-conn, 8-conn and 2-bit-label instances in lockstep
module tb_blob_counter_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, start, valid, pix, ack;
  logic [18:0] thr;
  logic rdy4, ov4, ovf4, rdy8, ov8, ovf8, rdy2, ov2, ovf2;
  logic [7:0] cnt4, cnt8;
  logic [1:0] cnt2;
  logic [18:0] ma4, ma8, ma2;
  int tests = 0;
  int failed = 0;
  int lat;
  bit seen;

`ifdef BLOB_MAX_AREA_EN
  `define MA_PORT(x) , .o_max_area(x)
`else
  `define MA_PORT(x)
`endif

  blob_counter_param #(.IMG_W(8), .IMG_H(4), .LBL_BITS(8), .AREA_BITS(19), .CONNECT8(0)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_min_area(thr), .i_valid(valid), .i_pix(pix),
    .o_ready(rdy4), .o_valid(ov4), .i_ack(ack), .o_count(cnt4), .o_overflow(ovf4) `MA_PORT(ma4));
  blob_counter_param #(.IMG_W(8), .IMG_H(4), .LBL_BITS(8), .AREA_BITS(19), .CONNECT8(1)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_min_area(thr), .i_valid(valid), .i_pix(pix),
    .o_ready(rdy8), .o_valid(ov8), .i_ack(ack), .o_count(cnt8), .o_overflow(ovf8) `MA_PORT(ma8));
  blob_counter_param #(.IMG_W(8), .IMG_H(4), .LBL_BITS(2), .AREA_BITS(19), .CONNECT8(0)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_min_area(thr), .i_valid(valid), .i_pix(pix),
    .o_ready(rdy2), .o_valid(ov2), .i_ack(ack), .o_count(cnt2), .o_overflow(ovf2) `MA_PORT(ma2));

`ifndef BLOB_MAX_AREA_EN
  assign ma4 = '0;
  assign ma8 = '0;
  assign ma2 = '0;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // img bit r*8+c is the pixel at row r, column c
  task automatic run_frame(input logic [31:0] img, input logic [18:0] th, input bit gaps,
                           input int abort_at, output int l);
    int t;
    bit acc;
    start = 1'b1;
    thr = th;
    tick;
    start = 1'b0;
    t = 0;
    while (!(rdy4 && rdy8 && rdy2) && t < 1000) begin
      tick;
      t++;
    end
    chk("stream_entry", {31'b0, rdy4 && rdy8 && rdy2}, 1);
    for (int p = 0; p < 32; p++) begin
      if (p == abort_at) begin
        valid = 1'b0;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        l = 0;
        return;
      end
      pix = img[p];
      do begin
        valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        acc = valid;
        tick;
      end while (!acc);
      valid = 1'b0;
    end
    l = 0;
    while (!ov4 && l < 2000) begin
      tick;
      l++;
    end
    t = 0;
    while (!(ov4 && ov8 && ov2) && t < 2000) begin
      tick;
      t++;
    end
  endtask

  task automatic finish_frame(input string tag, input int e4, input int e8, input int e2,
                              input int f4, input int f8, input int f2, input int m4,
                              input int l, input int el);
    chk({tag, ".latency"}, l, el);
    chk({tag, ".count4"}, {24'b0, cnt4}, e4);
    chk({tag, ".count8"}, {24'b0, cnt8}, e8);
    chk({tag, ".count2"}, {30'b0, cnt2}, e2);
    chk({tag, ".ovf4"}, {31'b0, ovf4}, f4);
    chk({tag, ".ovf8"}, {31'b0, ovf8}, f8);
    chk({tag, ".ovf2"}, {31'b0, ovf2}, f2);
`ifdef BLOB_MAX_AREA_EN
    chk({tag, ".max_area"}, {13'b0, ma4}, m4);
`endif
    repeat (3) tick;
    chk({tag, ".valid_held"}, {29'b0, ov4, ov8, ov2}, 7);
    chk({tag, ".count_held"}, {24'b0, cnt4}, e4);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    chk({tag, ".valid_drop"}, {29'b0, ov4, ov8, ov2}, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    pix = 1'b0;
    ack = 1'b0;
    thr = '0;
    repeat (3) tick;
    chk("reset.valid", {29'b0, ov4, ov8, ov2}, 0);
    chk("reset.ready", {29'b0, rdy4, rdy8, rdy2}, 0);
    chk("reset.ovf", {29'b0, ovf4, ovf8, ovf2}, 0);
    chk("reset.count", {14'b0, cnt4, cnt8, cnt2}, 0);
    rst = 1'b0;
    tick;
    run_frame(32'h0000_0000, 19'd1, 1'b0, -1, lat);
    finish_frame("zeros", 0, 0, 0, 0, 0, 0, 0, lat, 2);
    run_frame(32'h0000_3333, 19'd1, 1'b0, -1, lat);
    finish_frame("squares_t1", 2, 2, 2, 0, 0, 0, 4, lat, 8);
    run_frame(32'h0000_3333, 19'd5, 1'b0, -1, lat);
    finish_frame("squares_t5", 0, 0, 0, 0, 0, 0, 4, lat, 8);
    run_frame(32'h0F09_0909, 19'd10, 1'b0, -1, lat);
    finish_frame("u_t10", 1, 1, 1, 0, 0, 0, 10, lat, 8);
    run_frame(32'h0F09_0909, 19'd11, 1'b0, -1, lat);
    finish_frame("u_t11", 0, 0, 0, 0, 0, 0, 10, lat, 8);
    run_frame(32'h0804_0201, 19'd1, 1'b0, -1, lat);
    finish_frame("diag", 4, 1, 3, 0, 0, 1, 1, lat, 14);
    run_frame(32'hB18C_C555, 19'd2, 1'b1, 12, lat);
    chk("abort.valid", {29'b0, ov4, ov8, ov2}, 0);
    chk("abort.ready", {29'b0, rdy4, rdy8, rdy2}, 0);
    chk("abort.count", {14'b0, cnt4, cnt8, cnt2}, 0);
    seen = 1'b0;
    repeat (60) begin
      tick;
      seen = seen | ov4 | ov8 | ov2;
    end
    chk("abort.no_result", {31'b0, seen}, 0);
    run_frame(32'hB18C_C555, 19'd2, 1'b1, -1, lat);
    finish_frame("gaps", 4, 3, 2, 0, 0, 1, 5, lat, 20);
    run_frame(32'h0000_3333, 19'd1, 1'b1, -1, lat);
    finish_frame("ovf_cleared", 2, 2, 2, 0, 0, 0, 4, lat, 8);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/blob_counter_param.md
Name: blob_counter_param

Overview:
- Streaming connected-component counter for binary camera frames; successor to the fixed 640x480 single-mode blob counter.
- Labels foreground pixels in raster order using a one-row label line buffer and an equivalence (parent) table.
- After the last pixel it resolves equivalences, merges areas and counts components whose area is at least a runtime threshold.
- Sits after the binarising stage in the camera pipeline; its result feeds the display/seven-segment logic.

Parameters:
- IMG_W, 640, pixels per row.
- IMG_H, 480, rows per frame.
- LBL_BITS, 8, label width; labels 1..2^LBL_BITS-1 usable, label 0 = background.
- AREA_BITS, 19, per-label area counter width; saturates at all-ones.
- CONNECT8, 0, 0 = 4-connectivity (W, N); 1 = 8-connectivity (W, NW, N, NE).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  1-cycle pulse in IDLE: begin new frame
- i_min_area  in  AREA_BITS  area threshold; sampled on i_start
- i_valid  in  1  pixel valid
- i_pix  in  1  pixel value, 1 = foreground
- o_ready  out  1  pixel accepted when i_valid & o_ready
- o_valid  out  1  result valid; held until i_ack
- i_ack  in  1  result consumed
- o_count  out  LBL_BITS  number of qualifying blobs
- o_overflow  out  1  labels ran out during frame

Behaviour:
- Reset: all outputs 0, state IDLE, tables contents don't-care (always cleared before use).
- States: IDLE -> CLEAR -> STREAM -> RESOLVE -> MERGE -> COUNT -> OUT -> IDLE.
- IDLE: o_ready=0; i_start -> CLEAR; latch threshold, clear count and overflow.
- CLEAR: one table entry per cycle: parent[i]=i, area[i]=0; zero line buffer in parallel. Lasts max(2^LBL_BITS, IMG_W) cycles.
- STREAM: o_ready=1; row/col counters advance only on accept; i_valid low stalls with no state change.
  - Neighbours outside the image (row 0, col 0, col IMG_W-1 for NE) read as 0.
  - Background pixel: label 0.
  - Foreground pixel: let P = parent lookup of a raw label; zero neighbours are ignored.
  - 4-conn: if W and N both nonzero, a=W, b=N; else the single nonzero neighbour.
  - 8-conn: if N nonzero, use N. Else if NE is nonzero and one of W/NW is nonzero (W has priority), a=that, b=NE. Else the first nonzero of W, NW, NE.
  - Pair case: ra=P(a), rb=P(b); label=min(ra,rb); if ra!=rb, write parent[max]=min.
  - Single case: label=P(neighbour).
  - No neighbour: allocate next free label. If none remain, label=0, pixel dropped, o_overflow=1 (sticky until next i_start).
  - area[label] += 1 when label != 0.
  - Parent/area writes from cycle n are visible to reads in cycle n+1 (bypass required).
  - The raw assigned label goes into the line buffer.
  - The last accepted pixel (row IMG_H-1, col IMG_W-1) -> RESOLVE.
- RESOLVE: i ascending 1..last_alloc, one per cycle: parent[i]=parent[parent[i]]. Valid because parent[i] <= i always.
- MERGE: i descending last_alloc..1: if parent[i]!=i, area[parent[i]] += area[i] (saturating).
- COUNT: i ascending 1..last_alloc: if parent[i]==i and area[i] >= threshold, count++. o_count saturates at all-ones.
- OUT: o_valid=1 with stable o_count/o_overflow; on i_ack, o_valid drops next cycle, state -> IDLE.
- Latency from last accepted pixel to o_valid: 3*last_alloc+2 cycles.
- i_start is ignored outside IDLE. i_valid is ignored outside STREAM.
- i_rst at any point aborts the frame and forces IDLE with outputs 0.

Optional Feature:
- BLOB_MAX_AREA_EN defined: adds output o_max_area (AREA_BITS), the largest root area computed during COUNT with no extra cycles, valid with o_valid and reset to 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- 8x4 frame (IMG_W=8, IMG_H=4), all zeros -> o_count=0, o_overflow=0, o_valid stays until i_ack.
- Two disjoint 2x2 squares, threshold 1 -> o_count=2; threshold 5 -> o_count=0.
- U-shape: two columns joined at the bottom row, 4-conn -> o_count=1, merged area equals total foreground pixels. With BLOB_MAX_AREA_EN, o_max_area equals that area.
- Diagonal line, CONNECT8=0 -> count = pixel count (threshold 1); CONNECT8=1 -> o_count=1.
- LBL_BITS=2 with 4 isolated pixels -> o_overflow=1, o_count=3.
- Random i_valid gaps, plus an i_rst mid-STREAM followed by a clean frame -> o_count matches the golden model; no result is emitted for the aborted frame.
